// File: rtl/nn_ctrl_pkg.sv
// Shared types and constants for the inference sequencer and its helpers.
package nn_ctrl_pkg;

    localparam int Q88_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        RESET_NN,
        WAIT_FRAME,
        START_NN,
        WAIT_NN,
        CAPTURE
    } seq_state_t;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for an asynchronous input plus a one-cycle rising-edge pulse.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/nn_inference_sequencer.sv
// Control sequencer: collects a serial frame, starts the NN core, and captures/classifies its argmax.
//
// state      | meaning
// IDLE       | waiting for start_i or continuous mode
// RESET_NN   | holding nn_reset_o for NN_RST_CYCLES
// WAIT_FRAME | counting synchronised ser_clk_i rising edges
// START_NN   | first cycle of nn_valid_o, watchdog starts
// WAIT_NN    | waiting for max_valid_i under the watchdog
// CAPTURE    | result just latched, re-arm or go idle
module nn_inference_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter  int NUM_CLASSES    = 10,
    parameter  int VALUE_W        = Q88_W,
    parameter  int FRAME_BITS     = 12544,
    parameter  int NN_RST_CYCLES  = 1,
    parameter  int TIMEOUT_CYCLES = 65535,
    parameter  int SYNC_STAGES    = 2,
    localparam int IDX_W          = $clog2(NUM_CLASSES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ser_clk_i,
    input  logic               start_i,
    input  logic               mode_cont_i,
    input  logic               abort_i,
    input  logic               clear_err_i,
    input  logic [VALUE_W-1:0] conf_thresh_i,
    input  logic               max_valid_i,
    input  logic [IDX_W-1:0]   max_idx_i,
    input  logic [VALUE_W-1:0] max_value_i,
    output logic               nn_reset_o,
    output logic               nn_valid_o,
    output logic [IDX_W-1:0]   result_idx_o,
    output logic [VALUE_W-1:0] result_value_o,
    output logic               result_valid_o,
    output logic               low_conf_o,
    output logic               timeout_err_o,
    output logic               busy_o,
    output logic [15:0]        frames_done_o
);

    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RST_W = $clog2(NN_RST_CYCLES + 1);

    localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(FRAME_BITS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(NN_RST_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [RST_W-1:0] rst_cnt_q;
    logic             ser_rise;
    logic             capture;
    logic             timeout;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ser_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (ser_clk_i),
        .rise_o  (ser_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        timeout    = 1'b0;
        nn_reset_o = 1'b0;
        nn_valid_o = 1'b0;
        case (state_q)
            IDLE:       if (start_i || mode_cont_i) state_d = RESET_NN;
            RESET_NN: begin
                nn_reset_o = 1'b1;
                if (rst_cnt_q == RST_LAST) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: if (bit_cnt_q == BIT_FULL) state_d = START_NN;
            START_NN: begin
                nn_valid_o = 1'b1;
                state_d    = WAIT_NN;
            end
            WAIT_NN: begin
                nn_valid_o = 1'b1;
                // A result arriving on the last watchdog cycle still counts.
                if (max_valid_i) begin
                    capture = 1'b1;
                    state_d = CAPTURE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            CAPTURE:    state_d = mode_cont_i ? RESET_NN : IDLE;
            default:    state_d = IDLE;
        endcase
        if (abort_i && state_q != IDLE) begin
            state_d = IDLE;
            capture = 1'b0;
            timeout = 1'b0;
        end
    end

    assign busy_o = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rst_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            tmo_cnt_q      <= '0;
            result_idx_o   <= '0;
            result_value_o <= '0;
            result_valid_o <= 1'b0;
            low_conf_o     <= 1'b0;
            timeout_err_o  <= 1'b0;
            frames_done_o  <= '0;
        end else begin
            rst_cnt_q <= (state_q == RESET_NN) ? rst_cnt_q + RST_W'(1) : '0;

            if (state_q != WAIT_FRAME)
                bit_cnt_q <= '0;
            else if (ser_rise && bit_cnt_q != BIT_FULL)
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);

            // Counts from the START_NN cycle so the error lands TIMEOUT_CYCLES after start.
            if (state_q == START_NN || state_q == WAIT_NN)
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            else
                tmo_cnt_q <= '0;

            result_valid_o <= capture;
            if (capture) begin
                result_idx_o   <= max_idx_i;
                result_value_o <= max_value_i;
                low_conf_o     <= ($signed(max_value_i) < $signed(conf_thresh_i));
                frames_done_o  <= frames_done_o + 16'd1;
            end

            if (timeout)          timeout_err_o <= 1'b1;
            else if (clear_err_i) timeout_err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Directed bench for nn_inference_sequencer with a scoreboard of expected core results.
module tb_nn_inference_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ser_clk_i;
    logic        start_i;
    logic        mode_cont_i;
    logic        abort_i;
    logic        clear_err_i;
    logic [15:0] conf_thresh_i;
    logic        max_valid_i;
    logic [3:0]  max_idx_i;
    logic [15:0] max_value_i;
    logic        nn_reset_o;
    logic        nn_valid_o;
    logic [3:0]  result_idx_o;
    logic [15:0] result_value_o;
    logic        result_valid_o;
    logic        low_conf_o;
    logic        timeout_err_o;
    logic        busy_o;
    logic [15:0] frames_done_o;

    nn_inference_sequencer #(
        .NUM_CLASSES    (10),
        .VALUE_W        (16),
        .FRAME_BITS     (8),
        .NN_RST_CYCLES  (1),
        .TIMEOUT_CYCLES (32),
        .SYNC_STAGES    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ser_clk_i      (ser_clk_i),
        .start_i        (start_i),
        .mode_cont_i    (mode_cont_i),
        .abort_i        (abort_i),
        .clear_err_i    (clear_err_i),
        .conf_thresh_i  (conf_thresh_i),
        .max_valid_i    (max_valid_i),
        .max_idx_i      (max_idx_i),
        .max_value_i    (max_value_i),
        .nn_reset_o     (nn_reset_o),
        .nn_valid_o     (nn_valid_o),
        .result_idx_o   (result_idx_o),
        .result_value_o (result_value_o),
        .result_valid_o (result_valid_o),
        .low_conf_o     (low_conf_o),
        .timeout_err_o  (timeout_err_o),
        .busy_o         (busy_o),
        .frames_done_o  (frames_done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] val;
        logic        lc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_results = 0;
    int   rst_pulses = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    logic rv_prev = 1'b0;
    logic nv_prev = 1'b0;
    logic nr_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ser_edges(input int n);
        for (int i = 0; i < n; i++) begin
            ser_clk_i = 1'b1;
            tick(3);
            ser_clk_i = 1'b0;
            tick(3);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (nn_valid_o !== 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
        check("wait_nn_valid", nn_valid_o, 1);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
    endtask

    // Behavioural core: answers after dly cycles; expected result queued first.
    task automatic core_respond(input int dly, input logic [3:0] idx, input logic [15:0] val);
        exp_t e;
        tick(dly);
        e.idx = idx;
        e.val = val;
        e.lc  = ($signed(val) < $signed(conf_thresh_i));
        sb_q.push_back(e);
        max_valid_i = 1'b1;
        max_idx_i   = idx;
        max_value_i = val;
        tick(1);
        max_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rv_prev) check("rv_one_cycle", result_valid_o, 0);
        if (result_valid_o === 1'b1) begin
            n_results++;
            if (sb_q.size() == 0) begin
                check("unexpected_result", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check("res_idx", result_idx_o, mon_e.idx);
                check("res_value", result_value_o, mon_e.val);
                check("res_low_conf", low_conf_o, mon_e.lc);
            end
        end
        if (nn_valid_o && !nv_prev) start_cyc = cyc;
        if (nn_reset_o && !nr_prev) rst_pulses++;
        rv_prev = result_valid_o;
        nv_prev = nn_valid_o;
        nr_prev = nn_reset_o;
    end

    initial begin
        int n;
        int base_rst;
        int base_res;

        reset         = 1'b1;
        ser_clk_i     = 1'b0;
        start_i       = 1'b0;
        mode_cont_i   = 1'b0;
        abort_i       = 1'b0;
        clear_err_i   = 1'b0;
        conf_thresh_i = 16'h0100;
        max_valid_i   = 1'b0;
        max_idx_i     = 4'd0;
        max_value_i   = 16'h0000;
        tick(3);

        check("rst_busy", busy_o, 0);
        check("rst_nn_reset", nn_reset_o, 0);
        check("rst_nn_valid", nn_valid_o, 0);
        check("rst_result_valid", result_valid_o, 0);
        check("rst_frames", frames_done_o, 0);
        check("rst_timeout_err", timeout_err_o, 0);
        check("rst_result_idx", result_idx_o, 0);
        reset = 1'b0;
        tick(2);

        // 1: single shot, confident result
        start_i = 1'b1;
        tick(1);
        check("t1_nn_reset", nn_reset_o, 1);
        check("t1_busy", busy_o, 1);
        start_i = 1'b0;
        ser_edges(8);
        wait_valid();
        core_respond(20, 4'd7, 16'h0180);
        tick(2);
        check("t1_frames", frames_done_o, 1);
        check("t1_busy_idle", busy_o, 0);
        check("t1_idx", result_idx_o, 7);
        check("t1_low_conf", low_conf_o, 0);

        // 2: low confidence, positive then negative value
        pulse_start();
        ser_edges(8);
        wait_valid();
        core_respond(5, 4'd3, 16'h0080);
        tick(2);
        check("t2a_low_conf", low_conf_o, 1);
        check("t2a_frames", frames_done_o, 2);
        pulse_start();
        ser_edges(8);
        wait_valid();
        core_respond(5, 4'd9, 16'hFF00);
        tick(2);
        check("t2b_low_conf", low_conf_o, 1);
        check("t2b_frames", frames_done_o, 3);

        // 3: watchdog, error 32 cycles after START_NN
        pulse_start();
        ser_edges(8);
        wait_valid();
        n = 0;
        while (timeout_err_o !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        check("t3_timeout_err", timeout_err_o, 1);
        check("t3_latency", cyc - start_cyc, 32);
        check("t3_nn_valid", nn_valid_o, 0);
        check("t3_busy", busy_o, 0);
        check("t3_idx_held", result_idx_o, 9);
        check("t3_frames_held", frames_done_o, 3);
        clear_err_i = 1'b1;
        tick(1);
        clear_err_i = 1'b0;
        check("t3_clear_err", timeout_err_o, 0);

        // 4: continuous mode, three frames from a fresh reset
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check("t4_frames_reset", frames_done_o, 0);
        base_rst    = rst_pulses;
        base_res    = n_results;
        mode_cont_i = 1'b1;
        for (int f = 0; f < 3; f++) begin
            tick(2);
            ser_edges(8);
            wait_valid();
            core_respond(4, 4'(f + 1), 16'h0200 + 16'(f));
            if (f == 2) mode_cont_i = 1'b0;
        end
        tick(3);
        check("t4_rst_pulses", rst_pulses - base_rst, 3);
        check("t4_results", n_results - base_res, 3);
        check("t4_frames", frames_done_o, 3);
        check("t4_busy", busy_o, 0);

        // 5: abort in WAIT_NN, then abort together with max_valid_i
        pulse_start();
        ser_edges(8);
        wait_valid();
        tick(3);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        check("t5_busy", busy_o, 0);
        check("t5_nn_valid", nn_valid_o, 0);
        check("t5_idx_held", result_idx_o, 3);
        check("t5_value_held", result_value_o, 16'h0202);
        pulse_start();
        ser_edges(8);
        wait_valid();
        tick(3);
        abort_i     = 1'b1;
        max_valid_i = 1'b1;
        max_idx_i   = 4'd5;
        max_value_i = 16'h0700;
        tick(1);
        abort_i     = 1'b0;
        max_valid_i = 1'b0;
        check("t5_abort_no_rv", result_valid_o, 0);
        check("t5_abort_busy", busy_o, 0);
        tick(1);
        check("t5_abort_no_rv2", result_valid_o, 0);
        check("t5_abort_frames", frames_done_o, 3);
        max_valid_i = 1'b1;
        tick(1);
        max_valid_i = 1'b0;
        tick(1);
        check("t5_idle_mv_ignored", frames_done_o, 3);

        // 6: reset mid-frame, then a full fresh frame; start_i while busy
        pulse_start();
        ser_edges(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_busy_after_reset", busy_o, 0);
        check("t6_frames_after_reset", frames_done_o, 0);
        pulse_start();
        tick(1);
        ser_edges(7);
        tick(10);
        check("t6_partial_no_valid", nn_valid_o, 0);
        check("t6_partial_busy", busy_o, 1);
        start_i = 1'b1;
        tick(2);
        start_i = 1'b0;
        ser_edges(1);
        wait_valid();
        core_respond(6, 4'd2, 16'h0300);
        tick(3);
        check("t6_frames", frames_done_o, 1);
        check("t6_idx", result_idx_o, 2);
        check("t6_busy_idle", busy_o, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
